// File: rtl/mem_refill_responder_if.sv
// Request/response channel between the data cache and its refill responder.
// master = cache side, slave = memory responder side.
interface mem_refill_responder_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 17,
  parameter int BYTE_WIDTH    = 8
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                     ReqValid;
  logic                     ReqReady;
  logic                     ReqWrite;
  logic [ADDRESS_WIDTH-1:0] ReqAddr;
  logic [DATA_WIDTH-1:0]    ReqWData;
  logic [NBYTES-1:0]        ReqByteEn;
  logic                     RespValid;
  logic [DATA_WIDTH-1:0]    RespData;
  logic                     RespLast;
  logic                     RespReady;
  logic                     Busy;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByteEn, RespReady,
    input  ReqReady, RespValid, RespData, RespLast, Busy
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData, ReqByteEn, RespReady,
    output ReqReady, RespValid, RespData, RespLast, Busy
  );
endinterface

// File: rtl/mem_refill_responder.sv
// Memory-side responder for cache line refills and write-through words.
// One request at a time; read returns a line burst, write returns a single ack beat.
//
//   state | meaning
//   IDLE  | ready for a request
//   WAIT  | modelled access delay, counting down from LATENCY
//   BURST | streaming line words base+0 .. base+(BLOCK_WORDS-1)
//   WACK  | single write acknowledge beat
module mem_refill_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 17,
  parameter int BYTE_WIDTH    = 8,
  parameter int BLOCK_WORDS   = 4,
  parameter int LATENCY       = 3
) (
  input logic CLK,
  input logic RST,
  mem_refill_responder_if.slave bus
);
  localparam int NBYTES   = DATA_WIDTH / BYTE_WIDTH;
  localparam int WORD_OFF = $clog2(NBYTES);
  localparam int WIDX_W   = ADDRESS_WIDTH - WORD_OFF;
  localparam int NWORDS   = 2 ** WIDX_W;
  localparam int BEAT_W   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int CNT_W    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WACK} stateType;

  stateType              state;
  logic [CNT_W-1:0]      waitCnt;
  logic [BEAT_W-1:0]     beatCnt;
  logic [WIDX_W-1:0]     lineIdx;
  logic                  isWrite;
  logic                  respValid;
  logic                  respLast;
  logic [DATA_WIDTH-1:0] respData;

  logic [DATA_WIDTH-1:0] mem [NWORDS];

  logic              accept;
  logic              goResp;
  logic              goWrite;
  logic [WIDX_W-1:0] reqWordIdx;
  logic [WIDX_W-1:0] reqLineIdx;
  logic [WIDX_W-1:0] rdIdx;
  logic              unusedAddrBits;

  assign bus.ReqReady  = (state == IDLE) && !RST;
  assign bus.Busy      = (state != IDLE);
  assign bus.RespValid = respValid;
  assign bus.RespLast  = respLast;
  assign bus.RespData  = respData;

  assign accept         = bus.ReqValid && bus.ReqReady;
  assign reqWordIdx     = bus.ReqAddr[ADDRESS_WIDTH-1:WORD_OFF];
  assign reqLineIdx     = reqWordIdx & ~WIDX_W'(BLOCK_WORDS - 1);
  assign unusedAddrBits = ^bus.ReqAddr[WORD_OFF-1:0];

  // Response phase starts straight from the accept when there is no access delay.
  assign goResp  = (accept && (LATENCY == 0)) || ((state == WAIT) && (waitCnt == CNT_W'(1)));
  assign goWrite = (state == IDLE) ? bus.ReqWrite : isWrite;

  always_comb begin
    rdIdx = lineIdx;
    case (state)
      IDLE:    rdIdx = reqLineIdx;
      BURST:   rdIdx = lineIdx + WIDX_W'(beatCnt) + WIDX_W'(1);
      default: rdIdx = lineIdx;
    endcase
  end

  // Writes commit at the accept edge so a later read always sees them.
  always_ff @(posedge CLK) begin
    if (accept && bus.ReqWrite) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bus.ReqByteEn[b]) begin
          mem[reqWordIdx][b*BYTE_WIDTH +: BYTE_WIDTH] <= bus.ReqWData[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      waitCnt   <= '0;
      beatCnt   <= '0;
      lineIdx   <= '0;
      isWrite   <= 1'b0;
      respValid <= 1'b0;
      respLast  <= 1'b0;
      respData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            isWrite <= bus.ReqWrite;
            lineIdx <= reqLineIdx;
            beatCnt <= '0;
            if (LATENCY > 0) begin
              state   <= WAIT;
              waitCnt <= CNT_W'(LATENCY);
            end
          end
        end
        WAIT: waitCnt <= waitCnt - 1'b1;
        BURST: begin
          if (bus.RespReady) begin
            if (respLast) begin
              state     <= IDLE;
              respValid <= 1'b0;
              respLast  <= 1'b0;
              respData  <= '0;
            end else begin
              beatCnt  <= beatCnt + 1'b1;
              respData <= mem[rdIdx];
              respLast <= (int'(beatCnt) + 2 == BLOCK_WORDS);
            end
          end
        end
        WACK: begin
          if (bus.RespReady) begin
            state     <= IDLE;
            respValid <= 1'b0;
            respLast  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (goResp) begin
        respValid <= 1'b1;
        if (goWrite) begin
          state    <= WACK;
          respLast <= 1'b1;
          respData <= '0;
        end else begin
          state    <= BURST;
          respLast <= (BLOCK_WORDS == 1);
          respData <= mem[rdIdx];
        end
      end
    end
  end
endmodule
